line_doubler_fetch: RTL

//  Downstream consumer of the 640x480@60 sync generator. Fetches 320x240 source lines from framebuffer

---
 rtl/line_doubler_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/line_doubler_fetch.sv
// Fetches 320x240 source lines into a ping-pong line buffer one line ahead of display and
// replays each source pixel twice horizontally and each source line twice vertically.
module line_doubler_fetch #(
  parameter int              SRC_W    = 320,
  parameter int              SRC_H    = 240,
  parameter int              PIX_BITS = 8,
  parameter int              ADDR_W   = 17,
  parameter logic [ADDR_W-1:0] FB_BASE = '0,
  parameter int              V_LAST   = 523
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          CounterX,
  input  logic [9:0]          CounterY,
  input  logic                inDisplayArea,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [PIX_BITS-1:0] mem_data,
  output logic [PIX_BITS-1:0] pix_out,
  output logic                pix_de,
  output logic                h_sync_out,
  output logic                v_sync_out,
  output logic                fetch_underrun
);
  localparam int IDX_W  = $clog2(SRC_W);
  localparam int LINE_W = $clog2(SRC_H);
  localparam int BUF_AW = $clog2(2 * SRC_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SRC_W - 1);

  typedef enum logic {ST_IDLE, ST_FETCH} state_e;

  // Memory handshake: mem_req is held with a stable mem_addr until mem_ack; mem_data is
  // valid in the mem_ack cycle, and the next request (if any) follows on the next cycle.
  state_e              state_q, state_d;
  logic                bank_q, bank_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                underrun_q, underrun_d;
  logic [BUF_AW-1:0]   rd_idx_q, rd_idx_d;
  logic                de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [PIX_BITS-1:0] pix_q, pix_d;
  logic                de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;

  logic [PIX_BITS-1:0] line_buf [2*SRC_W];

  logic              trig;
  logic [LINE_W-1:0] trig_line;
  logic              wr_en;
  logic              last_ack;
  logic [BUF_AW-1:0] wr_idx;
  logic [8:0]        col_raw;
  logic [IDX_W-1:0]  col;

  always_comb begin
    trig      = 1'b0;
    trig_line = '0;
    if (CounterX == 10'd0) begin
      if (CounterY == 10'(V_LAST)) begin
        trig = 1'b1;
      end else if (CounterY[0] && (CounterY < 10'(2 * SRC_H - 1))) begin
        trig      = 1'b1;
        trig_line = LINE_W'((CounterY + 10'd1) >> 1);
      end
    end
  end

  assign wr_en    = (state_q == ST_FETCH) && mem_ack;
  assign last_ack = wr_en && (idx_q == IDX_LAST);
  assign wr_idx   = bank_q ? (BUF_AW'(SRC_W) + BUF_AW'(idx_q)) : BUF_AW'(idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      underrun_q <= 1'b0;
      rd_idx_q   <= '0;
      de1_q      <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      pix_q      <= '0;
      de2_q      <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      underrun_q <= underrun_d;
      rd_idx_q   <= rd_idx_d;
      de1_q      <= de1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      pix_q      <= pix_d;
      de2_q      <= de2_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
    end
  end

  // Line buffer has no reset; contents are only meaningful once a full line has landed.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[wr_idx] <= mem_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trig) state_d = ST_FETCH;
      ST_FETCH: begin
        if (trig)          state_d = ST_FETCH;
        else if (last_ack) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // A trigger always restarts the fetch; it only counts as an abort if the old line was unfinished.
  always_comb begin
    bank_d     = bank_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    underrun_d = underrun_q;
    if (trig) begin
      bank_d = trig_line[0];
      idx_d  = '0;
      addr_d = FB_BASE + ADDR_W'(trig_line) * ADDR_W'(SRC_W);
      if ((state_q == ST_FETCH) && !last_ack) underrun_d = 1'b1;
    end else if (wr_en && !last_ack) begin
      idx_d  = idx_q + 1'b1;
      addr_d = addr_q + 1'b1;
    end
  end

  always_comb begin
    mem_req        = (state_q == ST_FETCH);
    mem_addr       = addr_q;
    fetch_underrun = underrun_q;
  end

  // Columns past the source width fall in blanking; park them on column 0.
  always_comb begin
    col_raw  = CounterX[9:1];
    col      = ({1'b0, col_raw} < 10'(SRC_W)) ? IDX_W'(col_raw) : '0;
    rd_idx_d = CounterY[1] ? (BUF_AW'(SRC_W) + BUF_AW'(col)) : BUF_AW'(col);
    de1_d    = inDisplayArea;
    hs1_d    = h_sync_in;
    vs1_d    = v_sync_in;
    pix_d    = de1_q ? line_buf[rd_idx_q] : '0;
    de2_d    = de1_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
  end

  assign pix_out    = pix_q;
  assign pix_de     = de2_q;
  assign h_sync_out = hs2_q;
  assign v_sync_out = vs2_q;

endmodule
